io_responder: RTL and testbench
===============================

// Module: io_responder
// PURPOSE
//   Memory-side responder for the CPU's byte-wide memory bus, sitting between cpu and real_mem in the SoC top.
//   Decodes the I/O window, serves byte-mapped I/O registers (TX/RX FIFOs, status, halt, cycle counter)
//   and forwards all other accesses to RAM. Returns read data with the same 1-cycle latency as RAM.
// PARAMETERS
//   FIFO_DEPTH_LOG  4  log2 of TX and RX FIFO depth (16 entries each)
// PORTS
//   clk        in   1   system clock
//   rst        in   1   synchronous active-high reset
//   rdy        in   1   global ready; when 0 the bus is idle: no push/pop/halt side effects, counter frozen
//   mem_a      in   32  CPU byte address
//   mem_dout   in   8   CPU write data
//   mem_wr     in   1   CPU write enable (1 = write, 0 = read)
//   mem_din    out  8   read data to CPU, valid 1 cycle after address
//   ram_we     out  1   RAM write enable = mem_wr & ~io_sel & rdy
//   ram_dout   in   8   RAM read data (1-cycle latency)
//   tx_data    out  8   TX FIFO head byte
//   tx_valid   out  1   TX FIFO non-empty
//   tx_ready   in   1   sink accepts tx_data when tx_valid & tx_ready
//   rx_data    in   8   incoming byte
//   rx_valid   in   1   incoming byte valid
//   rx_ready   out  1   RX FIFO not full; byte captured when rx_valid & rx_ready
//   halt       out  1   sticky program-end flag
// BEHAVIOUR
//   - io_sel = (mem_a[17:16] == 2'b11). io_sel and I/O read data are registered; mem_din = io_sel_q ? io_rdata_q : ram_dout.
//   - Register map (byte offset mem_a[3:0] within window; unmapped offsets read 0x00, writes ignored):
//     0x0 W: push mem_dout to TX FIFO; if full, byte dropped and ovf set.  0x0 R: pop RX FIFO; returns 0x00 if empty.
//     0x4 R: status {5'b0, ovf, rx_nonempty, tx_full}.  0x4 W: set halt (any data value).
//     0x8 R: latch 32-bit counter snapshot, return byte0; 0x9/0xA/0xB R: snapshot bytes 1..3 (little-endian).
//   - Side effects occur only in a cycle with rdy=1, io_sel=1; one access per cycle.
//   - FIFOs: circular, pointers wrap modulo depth, count width FIFO_DEPTH_LOG+1.
//     TX: simultaneous CPU push and sink pop when full -> both succeed, count unchanged, no ovf.
//     RX: simultaneous capture and CPU pop when full -> pop only (rx_ready is 0 while full); when empty -> pop returns 0x00, capture succeeds.
//   - tx_data/tx_valid and rx_ready depend only on registered FIFO state (no combinational path from bus inputs).
//   - Counter: 32-bit, +1 per cycle with rdy=1, wraps 0xFFFFFFFF -> 0.
//   - Reset values: mem_din 0x00 path (io_sel_q=0, io_rdata_q=0), FIFOs empty, tx_valid 0, rx_ready 1,
//     ovf 0, halt 0, counter 0, snapshot 0. Reset mid-transfer discards all FIFO contents; ovf/halt are sticky until reset.
// CONFIGURATION
//   IO_CYCLE_COUNTER_EN defined: counter and snapshot registers present as above.
//   Not defined: no counter logic; offsets 0x8-0xB read 0x00.
// TESTING
//   1. Reset then read 0x30004 -> mem_din=0x00 next cycle; rx_ready=1, tx_valid=0, halt=0.
//   2. Write 0x41,0x42 to 0x30000 with tx_ready=0 -> tx_valid=1, tx_data=0x41; tx_ready=1 -> 0x41 then 0x42 leave, tx_valid=0.
//   3. 17 writes to 0x30000 with tx_ready=0 -> first 16 kept, status reads 0x05 (ovf|tx_full); drain yields bytes 1..16 in order.
//   4. rx_valid=1 rx_data=0x5A one cycle -> status=0x02; read 0x30000 -> 0x5A; read again -> 0x00, status=0x00.
//   5. Read/write 0x00001000 -> ram_we follows mem_wr, mem_din=ram_dout; write 0x30004 -> halt=1, no RAM write.
//   6. (IO_CYCLE_COUNTER_EN) hold rdy=0 N cycles, read 0x30008..B -> snapshot excludes stalled cycles; without macro -> 0x00.

Source files
------------

// File: rtl/io_responder_if.sv
// ---------------------------------------------------------------------------
// io_responder_if
//   CPU-side byte bus between the CPU (master) and the memory-side responder
//   (slave).
//   mem_a     CPU byte address            (master -> slave)
//   mem_dout  CPU write data              (master -> slave)
//   mem_wr    1 = write, 0 = read         (master -> slave)
//   mem_din   read data, 1 cycle latency  (slave  -> master)
// ---------------------------------------------------------------------------
interface io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    modport master (
        output mem_a,
        output mem_dout,
        output mem_wr,
        input  mem_din
    );

    modport slave (
        input  mem_a,
        input  mem_dout,
        input  mem_wr,
        output mem_din
    );
endinterface

// File: rtl/io_responder.sv
// ---------------------------------------------------------------------------
// io_responder
//   Memory-side responder between the CPU byte bus and RAM. Accesses with
//   mem_a[17:16] == 2'b11 hit the I/O window (TX/RX FIFOs, status, halt,
//   optional cycle counter); everything else goes to RAM. I/O read data is
//   registered so it lines up with the 1-cycle RAM read latency.
//
//   Register map (offset = mem_a[3:0]):
//     0x0 W  push TX FIFO (dropped and ovf set when full)
//     0x0 R  pop RX FIFO (0x00 when empty)
//     0x4 R  status {5'b0, ovf, rx_nonempty, tx_full}
//     0x4 W  set halt
//     0x8 R  latch cycle counter snapshot, return byte 0
//     0x9-0xB R  snapshot bytes 1..3
//
//   Optional feature: define IO_CYCLE_COUNTER_EN to build the 32-bit cycle
//   counter and snapshot register. Without it offsets 0x8-0xB read 0x00.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global ready; 0 = bus idle, no side effects
//   bus                 CPU byte bus (slave side)
//   ram_we, ram_dout    RAM write enable / RAM read data
//   tx_data, tx_valid, tx_ready   TX FIFO head to byte sink
//   rx_data, rx_valid, rx_ready   incoming bytes into RX FIFO
//   halt                sticky program-end flag
// ---------------------------------------------------------------------------
module io_responder #(
    parameter int FIFO_DEPTH_LOG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    io_responder_if.slave       bus,
    output logic                ram_we,
    input  logic [7:0]          ram_dout,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                halt
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam logic [FIFO_DEPTH_LOG:0] FULL_COUNT = (FIFO_DEPTH_LOG + 1)'(DEPTH);

    // ---------------- address decode ----------------
    logic       io_sel;
    logic [3:0] offset;
    logic       io_wr;
    logic       io_rd;
    logic       addr_unused;

    assign io_sel      = (bus.mem_a[17:16] == 2'b11);
    assign offset      = bus.mem_a[3:0];
    assign io_wr       = rdy & io_sel & bus.mem_wr;
    assign io_rd       = rdy & io_sel & ~bus.mem_wr;
    assign ram_we      = bus.mem_wr & ~io_sel & rdy;
    assign addr_unused = ^{bus.mem_a[31:18], bus.mem_a[15:4]};

    // ---------------- TX FIFO ----------------
    logic [7:0]                tx_mem [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] tx_wr_ptr_reg;
    logic [FIFO_DEPTH_LOG-1:0] tx_rd_ptr_reg;
    logic [FIFO_DEPTH_LOG:0]   tx_count_reg;
    logic                      tx_full;
    logic                      tx_pop;
    logic                      tx_push_req;
    logic                      tx_push;

    assign tx_full     = (tx_count_reg == FULL_COUNT);
    assign tx_valid    = (tx_count_reg != '0);
    assign tx_data     = tx_mem[tx_rd_ptr_reg];
    assign tx_pop      = tx_valid & tx_ready;
    assign tx_push_req = io_wr & (offset == 4'h0);
    // A push into a full FIFO still fits when the sink drains the head in the same cycle.
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);

    // ---------------- RX FIFO ----------------
    logic [7:0]                rx_mem [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] rx_wr_ptr_reg;
    logic [FIFO_DEPTH_LOG-1:0] rx_rd_ptr_reg;
    logic [FIFO_DEPTH_LOG:0]   rx_count_reg;
    logic                      rx_nonempty;
    logic                      rx_cap;
    logic                      rx_pop;

    assign rx_nonempty = (rx_count_reg != '0);
    // Driven from registered state only, so a pop cannot open space in the same cycle.
    assign rx_ready    = (rx_count_reg != FULL_COUNT);
    assign rx_cap      = rx_valid & rx_ready;
    assign rx_pop      = io_rd & (offset == 4'h0) & rx_nonempty;

    // ---------------- status / control ----------------
    logic       ovf_reg;
    logic       halt_reg;
    logic       io_sel_reg;
    logic [7:0] io_rdata_reg;
    logic [7:0] io_rdata_next;

    assign halt        = halt_reg;
    assign bus.mem_din = io_sel_reg ? io_rdata_reg : ram_dout;

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt_reg;
    logic [31:0] snapshot_reg;
`endif

    // ---------------- read mux ----------------
    always_comb begin
        io_rdata_next = 8'h00;
        if (io_rd) begin
            case (offset)
                4'h0: if (rx_nonempty) io_rdata_next = rx_mem[rx_rd_ptr_reg];
                4'h4: io_rdata_next = {5'b0, ovf_reg, rx_nonempty, tx_full};
`ifdef IO_CYCLE_COUNTER_EN
                // Byte 0 comes straight from the counter being latched this cycle.
                4'h8: io_rdata_next = cycle_cnt_reg[7:0];
                4'h9: io_rdata_next = snapshot_reg[15:8];
                4'hA: io_rdata_next = snapshot_reg[23:16];
                4'hB: io_rdata_next = snapshot_reg[31:24];
`endif
                default: io_rdata_next = 8'h00;
            endcase
        end
    end

    // ---------------- FIFO storage (no reset, pointers define contents) ----------------
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_reg] <= bus.mem_dout;
        if (rx_cap)  rx_mem[rx_wr_ptr_reg] <= rx_data;
    end

    // ---------------- control state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
            ovf_reg       <= 1'b0;
            halt_reg      <= 1'b0;
            io_sel_reg    <= 1'b0;
            io_rdata_reg  <= 8'h00;
        end else begin
            io_sel_reg   <= io_sel;
            io_rdata_reg <= io_rdata_next;

            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + FIFO_DEPTH_LOG'(1);
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + FIFO_DEPTH_LOG'(1);
            tx_count_reg <= tx_count_reg + (FIFO_DEPTH_LOG + 1)'(tx_push)
                                         - (FIFO_DEPTH_LOG + 1)'(tx_pop);

            if (rx_cap) rx_wr_ptr_reg <= rx_wr_ptr_reg + FIFO_DEPTH_LOG'(1);
            if (rx_pop) rx_rd_ptr_reg <= rx_rd_ptr_reg + FIFO_DEPTH_LOG'(1);
            rx_count_reg <= rx_count_reg + (FIFO_DEPTH_LOG + 1)'(rx_cap)
                                         - (FIFO_DEPTH_LOG + 1)'(rx_pop);

            if (tx_push_req && !tx_push)       ovf_reg  <= 1'b1;
            if (io_wr && (offset == 4'h4))     halt_reg <= 1'b1;
        end
    end

`ifdef IO_CYCLE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_reg <= 32'd0;
            snapshot_reg  <= 32'd0;
        end else begin
            if (rdy) cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (io_rd && (offset == 4'h8)) snapshot_reg <= cycle_cnt_reg;
        end
    end
`endif

endmodule

// File: tb/tb_io_responder.sv
// ---------------------------------------------------------------------------
// tb_io_responder
//   Directed bench for io_responder. Stimulus pushes expected read data and
//   expected TX bytes into queues; monitor processes pop and compare whenever
//   the DUT presents read data or a TX handshake. Inputs change 1 time unit
//   after the rising edge; monitors sample on the falling edge.
// ---------------------------------------------------------------------------
module tb_io_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       ram_we;
    logic [7:0] ram_dout;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       halt;

    io_responder_if bus_if ();

    io_responder #(.FIFO_DEPTH_LOG(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .bus      (bus_if),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .halt     (halt)
    );

    always #5 clk = ~clk;

    // Simple RAM model with 1-cycle read latency, indexed by the low address byte.
    logic [7:0] ram_mem [256];
    initial for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_we) ram_mem[bus_if.mem_a[7:0]] <= bus_if.mem_dout;
        ram_dout <= ram_mem[bus_if.mem_a[7:0]];
    end

    typedef struct {
        string      name;
        logic [7:0] exp;
    } rd_item_t;

    rd_item_t   rd_exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic       rd_en;
    logic       rd_pend = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // ---------------- monitors ----------------
    always @(posedge clk) rd_pend <= rd_en & rdy & ~rst;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no read", bus_if.mem_din);
            end else begin
                rd_item_t it;
                it = rd_exp_q.pop_front();
                check(it.name, {24'h0, bus_if.mem_din}, {24'h0, it.exp});
            end
        end
        if (tx_valid && tx_ready && !rst) begin
            if (tx_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
            end else begin
                logic [7:0] e;
                e = tx_exp_q.pop_front();
                check("tx_byte", {24'h0, tx_data}, {24'h0, e});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        bus_if.mem_a  = 32'h0;
        bus_if.mem_wr = 1'b0;
        rd_en         = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
        bus_if.mem_a    = addr;
        bus_if.mem_dout = data;
        bus_if.mem_wr   = 1'b1;
        rd_en           = 1'b0;
        @(posedge clk);
        #1;
        bus_if.mem_wr = 1'b0;
        bus_if.mem_a  = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [7:0] exp, input string name);
        rd_item_t it;
        it.name = name;
        it.exp  = exp;
        rd_exp_q.push_back(it);
        bus_if.mem_a  = addr;
        bus_if.mem_wr = 1'b0;
        rd_en         = 1'b1;
        @(posedge clk);
        #1;
        rd_en        = 1'b0;
        bus_if.mem_a = 32'h0;
    endtask

    task automatic tx_drain(input int budget);
        tx_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (!tx_valid && tx_exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("tx_drained_valid", {31'h0, tx_valid}, 32'h0);
        check("tx_drained_pending", tx_exp_q.size(), 32'h0);
        tx_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst             = 1'b1;
        rdy             = 1'b1;
        tx_ready        = 1'b0;
        rx_valid        = 1'b0;
        rx_data         = 8'h00;
        rd_en           = 1'b0;
        bus_if.mem_a    = 32'h0;
        bus_if.mem_dout = 8'h00;
        bus_if.mem_wr   = 1'b0;

        // 1. reset state
        do_reset();
        check("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("reset_halt", {31'h0, halt}, 32'h0);
        bus_read(32'h0003_0004, 8'h00, "reset_status");

        // 2. two TX bytes, then drain in order
        tx_exp_q.push_back(8'h41);
        bus_write(32'h0003_0000, 8'h41);
        tx_exp_q.push_back(8'h42);
        bus_write(32'h0003_0000, 8'h42);
        check("tx_valid_after_push", {31'h0, tx_valid}, 32'h1);
        check("tx_head", {24'h0, tx_data}, 32'h41);
        tx_drain(20);

        // 4. RX single byte, rdy gating, empty pop, capture during empty pop
        do_reset();
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        idle(1);
        rx_valid = 1'b0;
        bus_read(32'h0003_0004, 8'h02, "status_rx_nonempty");
        rdy          = 1'b0;
        bus_if.mem_a = 32'h0003_0000;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rdy = 1'b1;
        bus_read(32'h0003_0000, 8'h5A, "rx_pop");
        bus_read(32'h0003_0000, 8'h00, "rx_pop_empty");
        bus_read(32'h0003_0004, 8'h00, "status_rx_empty");
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        bus_read(32'h0003_0000, 8'h00, "rx_pop_empty_with_capture");
        rx_valid = 1'b0;
        bus_read(32'h0003_0000, 8'h77, "rx_capture_kept");

        // 3. TX overflow: 17 writes, 16 kept, ovf sticky
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) tx_exp_q.push_back(8'(i));
            bus_write(32'h0003_0000, 8'(i));
        end
        bus_read(32'h0003_0004, 8'h05, "status_tx_ovf_full");
        tx_drain(40);
        bus_read(32'h0003_0004, 8'h04, "status_ovf_sticky");

        // TX full with simultaneous push and sink pop: both succeed, no ovf
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            tx_exp_q.push_back(8'(i));
            bus_write(32'h0003_0000, 8'(i));
        end
        tx_ready = 1'b1;
        tx_exp_q.push_back(8'h99);
        bus_write(32'h0003_0000, 8'h99);
        tx_drain(40);
        bus_read(32'h0003_0004, 8'h00, "status_full_push_pop_no_ovf");

        // RX full: rx_ready drops, capture blocked during pop while full
        do_reset();
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'h10 + 8'(i);
            idle(1);
        end
        rx_valid = 1'b0;
        check("rx_ready_full", {31'h0, rx_ready}, 32'h0);
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        bus_read(32'h0003_0000, 8'h10, "rx_pop_while_full");
        rx_valid = 1'b0;
        for (int i = 1; i < 16; i++) bus_read(32'h0003_0000, 8'h10 + 8'(i), "rx_drain");
        bus_read(32'h0003_0000, 8'h00, "rx_full_capture_dropped");
        check("rx_ready_after_drain", {31'h0, rx_ready}, 32'h1);

        // Reset discards FIFO contents
        bus_write(32'h0003_0000, 8'h33);
        check("tx_valid_before_reset", {31'h0, tx_valid}, 32'h1);
        do_reset();
        check("tx_valid_after_reset", {31'h0, tx_valid}, 32'h0);

        // 5. RAM path, halt
        bus_if.mem_a    = 32'h0000_1000;
        bus_if.mem_dout = 8'hC3;
        bus_if.mem_wr   = 1'b1;
        #1;
        check("ram_we_mem_write", {31'h0, ram_we}, 32'h1);
        rdy = 1'b0;
        #1;
        check("ram_we_rdy_low", {31'h0, ram_we}, 32'h0);
        rdy = 1'b1;
        @(posedge clk);
        #1;
        bus_if.mem_wr = 1'b0;
        bus_read(32'h0000_1000, 8'hC3, "ram_read_back");
        bus_if.mem_a    = 32'h0003_0004;
        bus_if.mem_dout = 8'h5E;
        bus_if.mem_wr   = 1'b1;
        #1;
        check("ram_we_io_write", {31'h0, ram_we}, 32'h0);
        @(posedge clk);
        #1;
        bus_if.mem_wr = 1'b0;
        check("halt_set", {31'h0, halt}, 32'h1);
        bus_read(32'h0000_1004, 8'h00, "ram_untouched_by_io");
        bus_write(32'h0003_0002, 8'hAB);
        bus_read(32'h0003_0002, 8'h00, "unmapped_read");
        bus_read(32'h0003_000C, 8'h00, "unmapped_read_c");
        check("halt_sticky", {31'h0, halt}, 32'h1);

        // 6. cycle counter: 5 ready cycles, 7 stalled, then snapshot
        do_reset();
        idle(5);
        rdy = 1'b0;
        idle(7);
        rdy = 1'b1;
`ifdef IO_CYCLE_COUNTER_EN
        bus_read(32'h0003_0008, 8'h05, "snap_b0");
        bus_read(32'h0003_0009, 8'h00, "snap_b1");
        bus_read(32'h0003_000A, 8'h00, "snap_b2");
        bus_read(32'h0003_000B, 8'h00, "snap_b3");
        bus_read(32'h0003_0008, 8'h09, "snap2_b0");
`else
        bus_read(32'h0003_0008, 8'h00, "snap_b0_absent");
        bus_read(32'h0003_0009, 8'h00, "snap_b1_absent");
        bus_read(32'h0003_000A, 8'h00, "snap_b2_absent");
        bus_read(32'h0003_000B, 8'h00, "snap_b3_absent");
`endif

        idle(3);
        check("rd_queue_empty", rd_exp_q.size(), 32'h0);
        check("tx_queue_empty", tx_exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
